// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches against fetch predictions, issues redirects and owns the 2-bit PHT
module branch_resolve_unit #(
  parameter int IDX_BITS = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic [31:0] lookup_pc,
  output logic [1:0]  lookup_state,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);
  localparam int ENTRIES = 2 ** IDX_BITS;
  logic [1:0] pht [ENTRIES];
  logic accept, mispredict;
  logic [IDX_BITS-1:0] idx;
  logic [1:0] cur, nxt;
  // an event arriving while a redirect is in flight is wrong-path and ignored
  always_comb begin
    accept = ex_valid && !redirect_valid;
    mispredict = accept && (ex_is_branch ? (ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target) : ex_pred_taken);
    idx = ex_pc[IDX_BITS+1:2];
    cur = pht[idx];
    nxt = ex_taken ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
  end
  assign lookup_state = pht[lookup_pc[IDX_BITS+1:2]];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= INIT_STATE;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      br_count <= '0;
      mispred_count <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) redirect_pc <= (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
      if (accept && ex_is_branch) begin
        pht[idx] <= nxt;
        if (br_count != '1) br_count <= br_count + 32'd1;
      end
      if (mispredict && mispred_count != '1) mispred_count <= mispred_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: random and directed stimulus checked against a behavioural model of the resolve unit
module tb_branch_resolve_unit;
  logic clk = 0, reset = 1;
  logic ex_valid = 0, ex_is_branch = 0, ex_taken = 0, ex_pred_taken = 0;
  logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0, lookup_pc = 0;
  logic redirect_valid;
  logic [31:0] redirect_pc, br_count, mispred_count;
  logic [1:0] lookup_state;
  int checks = 0, fails = 0;
  bit chk = 0;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .lookup_pc(lookup_pc), .lookup_state(lookup_state), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int m_pht [64];
  bit m_rv;
  longint m_rpc, m_br, m_mis;
  bit m_acc, m_mp;

  // model: plain integer arithmetic on the rules, updated with the inputs present at the edge
  always @(posedge clk) begin
    if (reset) begin
      foreach (m_pht[i]) m_pht[i] = 1;
      m_rv = 0; m_rpc = 0; m_br = 0; m_mis = 0;
    end else begin
      m_acc = ex_valid && !m_rv;
      if (!m_acc) m_mp = 0;
      else if (ex_is_branch) m_mp = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
      else m_mp = ex_pred_taken;
      if (m_acc && ex_is_branch) begin
        m_pht[ex_pc[7:2]] = ex_taken ? ((m_pht[ex_pc[7:2]] < 3) ? m_pht[ex_pc[7:2]] + 1 : 3)
                                     : ((m_pht[ex_pc[7:2]] > 0) ? m_pht[ex_pc[7:2]] - 1 : 0);
        m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
      end
      if (m_mp) begin
        m_mis = (m_mis < 64'hFFFF_FFFF) ? m_mis + 1 : m_mis;
        m_rpc = (ex_is_branch && ex_taken) ? ex_target : (longint'(ex_pc) + 4) % 64'h1_0000_0000;
      end
      m_rv = m_mp;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk) begin
    check("redirect_valid", redirect_valid, m_rv);
    check("redirect_pc", redirect_pc, m_rpc);
    check("br_count", br_count, m_br);
    check("mispred_count", mispred_count, m_mis);
    check("lookup_state", lookup_state, m_pht[lookup_pc[7:2]]);
  end

  task automatic step(input bit v, input bit br, input logic [31:0] pc, input bit tk,
                      input logic [31:0] tgt, input bit pt, input logic [31:0] ptg);
    ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
    @(negedge clk); #1;
    ex_valid = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1;
    repeat (2) @(negedge clk);
    #1 reset = 0; chk = 1;
    lookup_pc = 32'h00; #1 check("init_lookup_00", lookup_state, 2'b01);
    lookup_pc = 32'h04; #1 check("init_lookup_04", lookup_state, 2'b01);
    lookup_pc = 32'hFC; #1 check("init_lookup_fc", lookup_state, 2'b01);
    check("init_br", br_count, 0);
    check("init_redirect", redirect_valid, 0);

    lookup_pc = 32'h40;
    step(1, 1, 32'h40, 1, 32'h1000, 0, 32'h0);
    check("t2_state1", lookup_state, 2'b10);
    check("t2_redirect", redirect_valid, 1);
    check("t2_rpc", redirect_pc, 32'h1000);
    idle();
    check("t2_redirect_off", redirect_valid, 0);
    step(1, 1, 32'h40, 1, 32'h1000, 1, 32'h1000);
    check("t2_state2", lookup_state, 2'b11);
    step(1, 1, 32'h40, 1, 32'h1000, 1, 32'h1000);
    step(1, 1, 32'h40, 1, 32'h1000, 1, 32'h1000);
    check("t2_state_sat", lookup_state, 2'b11);
    check("t2_br", br_count, 4);
    check("t2_mis", mispred_count, 1);
    check("t2_no_redirect", redirect_valid, 0);

    lookup_pc = 32'h100;
    step(1, 1, 32'h100, 1, 32'h300, 1, 32'h200);
    check("t3_rpc", redirect_pc, 32'h300);
    check("t3_redirect", redirect_valid, 1);
    check("t3_state", lookup_state, 2'b10);
    idle();

    lookup_pc = 32'h80;
    step(1, 0, 32'h80, 0, 32'h0, 1, 32'h500);
    check("t4_rpc", redirect_pc, 32'h84);
    check("t4_mis", mispred_count, 3);
    check("t4_br", br_count, 5);
    check("t4_state", lookup_state, 2'b01);
    idle();

    lookup_pc = 32'h20;
    step(1, 1, 32'h20, 0, 32'h0, 1, 32'h900);
    check("t5_rpc", redirect_pc, 32'h24);
    step(1, 1, 32'h20, 0, 32'h0, 1, 32'h900);
    check("t5_wrongpath_redirect", redirect_valid, 0);
    check("t5_wrongpath_br", br_count, 6);
    check("t5_wrongpath_state", lookup_state, 2'b00);

    lookup_pc = 32'h40;
    step(1, 1, 32'h40, 0, 32'h0, 1, 32'h1000);
    check("t6_redirect", redirect_valid, 1);
    reset = 1;
    @(negedge clk); #1 reset = 0;
    check("t6_rst_redirect", redirect_valid, 0);
    check("t6_rst_br", br_count, 0);
    check("t6_rst_mis", mispred_count, 0);
    check("t6_rst_state", lookup_state, 2'b01);

    lookup_pc = 32'h1C;
    ex_valid = 1; ex_is_branch = 1; ex_pc = 32'h1C; ex_taken = 1; ex_target = 32'h60;
    ex_pred_taken = 1; ex_pred_target = 32'h60;
    #1 check("same_idx_old", lookup_state, 2'b01);
    @(negedge clk); #1 ex_valid = 0;
    check("same_idx_new", lookup_state, 2'b10);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, tgt;
      bit tk, pt;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom_range(0, 127) << 2) | ($urandom_range(0, 3) << 20);
      tgt = ($urandom_range(0, 1) == 1) ? pc + 32'h10 : 32'h4000;
      tk = $urandom_range(0, 1);
      pt = $urandom_range(0, 1);
      lookup_pc = $urandom_range(0, 127) << 2;
      reset = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, pc, tk, tgt, pt,
           ($urandom_range(0, 3) == 0) ? 32'h4000 : pc + 32'h10);
      reset = 0;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
